// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
//
// Bit-serial unsigned adder. Operands are captured on an accepted start pulse
// and added LSB-first, one bit per clock, through a full-adder cell built from
// two cascaded half-adder equations and a carry flip-flop. After WIDTH bit
// steps the completed sum and carry-out are copied to the output registers and
// a one-cycle done pulse is raised.
//
// Optional build macro:
//   SERIAL_ADDER_OVF_EN - adds output port ovf (two's-complement overflow,
//                         carry into MSB XOR carry out of MSB), captured and
//                         held together with sum/cout.
//
// Reset: rst_n, synchronous, active-low.
// -----------------------------------------------------------------------------
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter just wide enough to hold WIDTH-1 (at least one bit).
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Half-adder stage: returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full-adder cell as two cascaded half adders: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic [1:0] ha0;
        logic [1:0] ha1;
        ha0 = half_add(x, y);        // {generate, propagate}
        ha1 = half_add(ha0[0], c);   // {propagate & carry, sum bit}
        return {ha0[1] | ha1[1], ha1[0]};
    endfunction

    // Sequential state
    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   psum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
    logic               ovf_d;
`endif

    // Next-state values for one bit step
    logic [1:0]         fa_s;
    logic [WIDTH-1:0]   a_sh_d;
    logic [WIDTH-1:0]   b_sh_d;
    logic [WIDTH-1:0]   psum_d;
    logic               carry_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               last_step_s;

    // Datapath for a single bit step: full add of the operand LSBs with the
    // carry flop, shift everything right, insert the new bit at the MSB.
    always_comb begin
        fa_s        = full_add(a_sh_q[0], b_sh_q[0], carry_q);
        carry_d     = fa_s[1];
        psum_d      = {fa_s[0], psum_q[WIDTH-1:1]};
        a_sh_d      = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = 1'b0;
        end
`ifdef SERIAL_ADDER_OVF_EN
        // On the final step carry_q is the carry into the MSB and carry_d the
        // carry out of it.
        ovf_d       = carry_q ^ carry_d;
`endif
    end

    // Control FSM with registered outputs; start is honoured in IDLE and DONE
    // so back-to-back operations need no idle gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            psum_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        psum_q  <= {WIDTH{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // start is deliberately ignored while running.
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    psum_q  <= psum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    if (last_step_s) begin
                        sum_q   <= psum_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
